// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared state encoding and sizing constants for the data-memory responder
package dmem_resp_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam int CNT_W = 4;
    localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response handshake bundle between core data port and responder
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_write;
    modport master (output req_valid, req_write, req_addr, req_wdata, rsp_ready,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write);
    modport slave  (input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write);
endinterface

// File: rtl/dmem_responder_word_array.sv
// dmem_word_array: word storage with synchronous write and asynchronous read
module dmem_word_array #(
  parameter int    DEPTH     = 256,
  parameter int    IDX_W     = 8,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[widx] <= wdata;
  assign rdata = mem[ridx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word memory behind a valid/ready request/response port
module dmem_responder
    import dmem_resp_pkg::*;
#(
    parameter int    DEPTH_WORDS = 256,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input logic              clk,
    input logic              reset,
    dmem_responder_if.slave  bus
);
    localparam int IDX_W = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q, wdata_q, acc_addr, acc_wdata, rdata;
    logic             write_q, accept, enter_resp, acc_write, acc_err;
    assign accept     = bus.req_valid & bus.req_ready;
    assign enter_resp = (state == WAIT && cnt == CNT_W'(1)) || (accept && LATENCY == 1);
    // With LATENCY=1 the access happens on the accept edge, so it must use the live request
    assign acc_addr   = state == WAIT ? addr_q  : bus.req_addr;
    assign acc_wdata  = state == WAIT ? wdata_q : bus.req_wdata;
    assign acc_write  = state == WAIT ? write_q : bus.req_write;
    assign acc_err    = |acc_addr[WORD_SHIFT-1:0] || acc_addr[31:WORD_SHIFT] >= (32-WORD_SHIFT)'(DEPTH_WORDS);
    dmem_word_array #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W), .INIT_FILE(INIT_FILE)) u_mem (
        .clk   (clk),
        .we    (enter_resp & acc_write & ~acc_err),
        .widx  (acc_addr[WORD_SHIFT +: IDX_W]),
        .wdata (acc_wdata),
        .ridx  (acc_addr[WORD_SHIFT +: IDX_W]),
        .rdata (rdata)
    );
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= nxt;
    always_comb begin
        nxt = accept ? (LATENCY == 1 ? RESP : WAIT) :
              (state == WAIT && cnt == CNT_W'(1)) ? RESP :
              (state == RESP && bus.rsp_ready) ? IDLE : state;
    end
    always_comb begin
        bus.req_ready = reset && (state == IDLE || (state == RESP && bus.rsp_ready));
        bus.rsp_valid = state == RESP;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt           <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_q       <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_write <= 1'b0;
        end else begin
            cnt <= accept ? CNT_W'(LATENCY - 1) : state == WAIT ? cnt - CNT_W'(1) : cnt;
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
            end
            if (enter_resp) begin
                bus.rsp_rdata <= (acc_write || acc_err) ? '0 : rdata;
                bus.rsp_err   <= acc_err;
                bus.rsp_write <= acc_write;
            end
        end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder, plus LATENCY=1/15 streaming builds
module tb_dmem_responder;
    logic clk = 0;
    logic reset = 0;
    int   tests = 0;
    int   fails = 0;
    bit   go6 = 0;
    bit   done6 [2];
    always #5 clk = ~clk;

    dmem_responder_if ifc();
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
    } vec_t;
    vec_t v [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        ifc.req_valid = 1;
        ifc.req_write = w;
        ifc.req_addr  = a;
        ifc.req_wdata = d;
    endtask

    // starts and ends one cycle-step after a rising edge
    task automatic xact(input vec_t t, input string nm);
        bit ok = 0;
        int n;
        drive(t.w, t.a, t.d);
        ifc.rsp_ready = 1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1 ok = ifc.req_ready;
            @(posedge clk); #1;
        end
        ifc.req_valid = 0;
        chk({nm, " accepted"}, 32'(ok), 1);
        n = 1;
        while (!ifc.rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, " latency"}, n, 2);
        chk({nm, " rdata"}, ifc.rsp_rdata, t.er);
        chk({nm, " err"}, 32'(ifc.rsp_err), 32'(t.ee));
        chk({nm, " write echo"}, 32'(ifc.rsp_write), 32'(t.w));
        @(posedge clk); #1;
        chk({nm, " rsp taken"}, 32'(ifc.rsp_valid), 0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g6
        localparam int L = g ? 15 : 1;
        dmem_responder_if sif();
        dmem_responder #(.LATENCY(L)) sdut (.clk(clk), .reset(reset), .bus(sif.slave));
        initial begin
            int idx = 0;
            int nrsp = 0;
            int last = 0;
            bit rdy, vld;
            sif.req_valid = 0;
            sif.req_write = 0;
            sif.req_addr  = 0;
            sif.req_wdata = 0;
            sif.rsp_ready = 1;
            done6[g] = 0;
            wait (go6);
            @(posedge clk); #1;
            for (int k = 0; k < 40 * L + 20 && nrsp < 40; k++) begin
                sif.req_valid = idx < 40;
                sif.req_write = idx < 20;
                sif.req_addr  = 32'(4 * (idx % 20));
                sif.req_wdata = 32'hA000_0000 + 32'(idx);
                #1;
                rdy = sif.req_ready;
                vld = sif.rsp_valid;
                if (vld) begin
                    chk($sformatf("L%0d rsp%0d spacing", L, nrsp), k - last, L);
                    chk($sformatf("L%0d rsp%0d rdata", L, nrsp), sif.rsp_rdata,
                        nrsp < 20 ? 32'h0 : 32'hA000_0000 + 32'(nrsp - 20));
                    chk($sformatf("L%0d rsp%0d write", L, nrsp), 32'(sif.rsp_write), 32'(nrsp < 20));
                    last = k;
                end
                @(posedge clk); #1;
                if (rdy && idx < 40) idx++;
                if (vld) nrsp++;
            end
            sif.req_valid = 0;
            chk($sformatf("L%0d response count", L), nrsp, 40);
            done6[g] = 1;
        end
    end

    initial begin
        bit ok;
        int n;
        v[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        v[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        v[2]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'h0,         1'b0};
        v[3]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0};
        v[4]  = '{1'b1, 32'h0000_0013, 32'h1111_1111, 32'h0,         1'b1};
        v[5]  = '{1'b0, 32'h0000_0400, 32'h0,         32'h0,         1'b1};
        v[6]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        v[7]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 32'h0,         1'b0};
        v[8]  = '{1'b0, 32'h0000_03FC, 32'h0,         32'hA5A5_A5A5, 1'b0};
        v[9]  = '{1'b0, 32'h0000_0012, 32'h0,         32'h0,         1'b1};
        v[10] = '{1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0,         1'b0};
        v[11] = '{1'b0, 32'h0000_0020, 32'h0,         32'h0BAD_F00D, 1'b0};
        v[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};

        drive(0, 32'h0, 32'h0);
        ifc.rsp_ready = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset req_ready", 32'(ifc.req_ready), 0);
        chk("reset rsp_valid", 32'(ifc.rsp_valid), 0);
        chk("reset rsp_rdata", ifc.rsp_rdata, 0);
        chk("reset rsp_err", 32'(ifc.rsp_err), 0);
        ifc.req_valid = 0;
        reset = 1;
        #1 chk("release req_ready", 32'(ifc.req_ready), 1);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) xact(v[i], $sformatf("vec%0d", i));

        drive(0, 32'h0, 32'h0);
        ifc.rsp_ready = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1 ok = ifc.req_ready;
            @(posedge clk); #1;
        end
        ifc.req_valid = 0;
        chk("bp accepted", 32'(ok), 1);
        n = 0;
        while (!ifc.rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        drive(1, 32'h8, 32'h0000_0077);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp hold%0d valid", i), 32'(ifc.rsp_valid), 1);
            chk($sformatf("bp hold%0d rdata", i), ifc.rsp_rdata, 32'hCAFE_F00D);
            chk($sformatf("bp hold%0d req_ready", i), 32'(ifc.req_ready), 0);
            @(posedge clk); #1;
        end
        ifc.rsp_ready = 1;
        #1 chk("bp release req_ready", 32'(ifc.req_ready), 1);
        @(posedge clk); #1;
        ifc.req_valid = 0;
        chk("bp both handshakes valid drop", 32'(ifc.rsp_valid), 0);
        @(posedge clk); #1;
        chk("bp store ack valid", 32'(ifc.rsp_valid), 1);
        chk("bp store ack write", 32'(ifc.rsp_write), 1);
        chk("bp store ack err", 32'(ifc.rsp_err), 0);
        @(posedge clk); #1;
        xact('{1'b0, 32'h8, 32'h0, 32'h0000_0077, 1'b0}, "bp reload");

        drive(1, 32'h20, 32'h1234_5678);
        #1 chk("mid-reset accept ready", 32'(ifc.req_ready), 1);
        @(posedge clk); #1;
        ifc.req_valid = 0;
        reset = 0;
        #1;
        chk("mid-reset rsp_valid", 32'(ifc.rsp_valid), 0);
        chk("mid-reset req_ready", 32'(ifc.req_ready), 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("post-reset quiet%0d", i), 32'(ifc.rsp_valid), 0);
            @(posedge clk); #1;
        end
        xact('{1'b0, 32'h20, 32'h0, 32'h0BAD_F00D, 1'b0}, "post-reset load");

        go6 = 1;
        n = 0;
        while (!(done6[0] && done6[1]) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("stream builds finished", 32'(done6[0] && done6[1]), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
